// File: rtl/du_pkg.sv
// Shared constants and encodings for the debug-unit dump transmitter.
package du_pkg;
  localparam int BYTE        = 8;
  localparam int DWORD       = 32;
  localparam int DEF_RB_ADDR = 5;
  localparam int DEF_ADDR    = 7;
  localparam int IDX_W       = $clog2(DWORD / BYTE);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_PC,
    LOAD_CYC,
    REQ_RB,
    WAIT_RB,
    REQ_MEM,
    WAIT_MEM,
    SEND,
    WAIT_TX,
    FINISH
  } state_t;

  // Which part of the frame the word currently in the latch belongs to
  typedef enum logic [1:0] {
    SEC_PC,
    SEC_CYC,
    SEC_RB,
    SEC_MEM
  } sec_t;

  function automatic int frame_words(input int rb_addr_w, input int addr_w);
    return 2 + (1 << rb_addr_w) + (1 << addr_w);
  endfunction

  localparam int FRAME_WORDS = frame_words(DEF_RB_ADDR, DEF_ADDR);
  localparam int FRAME_BYTES = FRAME_WORDS * (DWORD / BYTE);
endpackage

// File: rtl/du_word_serializer.sv
// Word latch plus byte index; presents the word little-endian, one byte at a time.
module du_word_serializer
  import du_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DWORD-1:0] word,
  input  logic             advance,
  output logic [BYTE-1:0]  cur_byte,
  output logic             last
);
  logic [DWORD-1:0] word_q;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx    <= '0;
    end else if (load) begin
      word_q <= word;
      idx    <= '0;
    end else if (advance) begin
      idx    <= idx + 1'b1;
    end
  end

  assign cur_byte = word_q[BYTE*idx +: BYTE];
  assign last     = (idx == IDX_W'(DWORD / BYTE - 1));
endmodule

// File: rtl/du_dump_tx.sv
// Streams PC, cycle count, register bank and data memory to the UART as one frame.
module du_dump_tx
  import du_pkg::*;
#(
  parameter int BYTE    = du_pkg::BYTE,
  parameter int DWORD   = du_pkg::DWORD,
  parameter int RB_ADDR = 5,
  parameter int ADDR    = 7
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [DWORD-1:0]   i_pc,
  input  logic [DWORD-1:0]   i_cycles,
  output logic [RB_ADDR-1:0] o_rb_addr,
  input  logic [DWORD-1:0]   i_rb_data,
  output logic [ADDR-1:0]    o_mem_addr,
  input  logic [DWORD-1:0]   i_mem_data,
  output logic [BYTE-1:0]    o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done_tick,
  output logic               o_busy,
  output logic               o_done
);
  state_t           state;
  sec_t             sec;
  logic             ser_load, ser_adv, last_byte;
  logic [DWORD-1:0] load_word;
  logic [BYTE-1:0]  cur_byte;

  // The latch loads in the cycle where the source word is valid
  assign ser_load = (state == LOAD_PC) || (state == LOAD_CYC) ||
                    (state == WAIT_RB) || (state == WAIT_MEM);
  assign ser_adv  = (state == WAIT_TX) && i_tx_done_tick && !last_byte;

  always_comb begin
    load_word = i_mem_data;
    case (state)
      LOAD_PC:  load_word = i_pc;
      LOAD_CYC: load_word = i_cycles;
      WAIT_RB:  load_word = i_rb_data;
      default:  load_word = i_mem_data;
    endcase
  end

  du_word_serializer u_ser (
    .clk      (i_clock),
    .rst      (i_reset),
    .load     (ser_load),
    .word     (load_word),
    .advance  (ser_adv),
    .cur_byte (cur_byte),
    .last     (last_byte)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      sec        <= SEC_PC;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rb_addr  <= '0;
      o_mem_addr <= '0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state      <= LOAD_PC;
          sec        <= SEC_PC;
          o_busy     <= 1'b1;
          o_rb_addr  <= '0;
          o_mem_addr <= '0;
        end
        LOAD_PC, LOAD_CYC, WAIT_RB, WAIT_MEM: state <= SEND;
        REQ_RB:  state <= WAIT_RB;
        REQ_MEM: state <= WAIT_MEM;
        SEND: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= cur_byte;
          state      <= WAIT_TX;
        end
        WAIT_TX: if (i_tx_done_tick) begin
          if (!last_byte) begin
            state <= SEND;
          end else begin
            // Word finished: pick the next source; addresses saturate at all-ones
            case (sec)
              SEC_PC: begin
                state <= LOAD_CYC;
                sec   <= SEC_CYC;
              end
              SEC_CYC: begin
                state <= REQ_RB;
                sec   <= SEC_RB;
              end
              SEC_RB: begin
                if (&o_rb_addr) begin
                  state <= REQ_MEM;
                  sec   <= SEC_MEM;
                end else begin
                  o_rb_addr <= o_rb_addr + 1'b1;
                  state     <= REQ_RB;
                end
              end
              default: begin
                if (&o_mem_addr) begin
                  state  <= FINISH;
                  o_done <= 1'b1;
                end else begin
                  o_mem_addr <= o_mem_addr + 1'b1;
                  state      <= REQ_MEM;
                end
              end
            endcase
          end
        end
        FINISH: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_du_dump_tx.sv
// Scoreboard bench: expected bytes are queued at stimulus time, a monitor checks each o_tx_start.
module tb_du_dump_tx;
  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_tx_done_tick = 1'b0;
  logic [31:0] i_pc = '0, i_cycles = '0;
  logic [31:0] i_rb_data = '0, i_mem_data = '0;
  logic [4:0]  o_rb_addr;
  logic [6:0]  o_mem_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_start, o_busy, o_done;

  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int n_start = 0, n_done = 0;
  int uart_delay = 10;
  bit spurious = 1'b0;
  int pend = 0;
  bit prev_real = 1'b0, fire;
  logic [7:0] held = '0;
  bit holding = 1'b0;

  always #5 i_clock = ~i_clock;

  du_dump_tx dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
    .i_pc(i_pc), .i_cycles(i_cycles),
    .o_rb_addr(o_rb_addr), .i_rb_data(i_rb_data),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done_tick(i_tx_done_tick),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Synchronous-read register bank and data memory: rb[i]=i, mem[j]=0xA5000000+j
  always @(posedge i_clock) begin
    i_rb_data  <= {27'b0, o_rb_addr};
    i_mem_data <= 32'hA500_0000 + {25'b0, o_mem_addr};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // UART model: done tick uart_delay cycles after each start; spurious mode stretches it one extra cycle
  always @(negedge i_clock) begin
    fire = 1'b0;
    if (i_reset) pend = 0;
    if (pend > 0) begin
      pend--;
      fire = (pend == 0);
    end
    i_tx_done_tick = fire || (spurious && prev_real);
    prev_real = fire;
    if (o_tx_start) pend = uart_delay;
  end

  // Monitor
  always @(negedge i_clock) begin
    if (i_reset) holding = 1'b0;
    if (o_tx_start) begin
      n_start++;
      got.push_back(o_tx_data);
      held = o_tx_data;
      holding = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got %h expected no byte", o_tx_data);
      end else begin
        check("tx_byte", {24'b0, o_tx_data}, {24'b0, exp_q.pop_front()});
      end
    end
    if (i_tx_done_tick && holding && !o_tx_start)
      check("tx_data_stable", {24'b0, o_tx_data}, {24'b0, held});
    if (o_done) n_done++;
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic push_frame(input logic [31:0] pc, input logic [31:0] cyc);
    push_word(pc);
    push_word(cyc);
    for (int r = 0; r < 32; r++) push_word(32'(r));
    for (int m = 0; m < 128; m++) push_word(32'hA500_0000 + 32'(m));
  endtask

  task automatic pulse_start();
    @(negedge i_clock) i_start = 1'b1;
    @(negedge i_clock) i_start = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [31:0] pc, input logic [31:0] cyc,
                           input int dly, input bit spur, input bit poke);
    int s0, d0, lat, cnt;
    bit poked;
    uart_delay = dly;
    spurious   = spur;
    i_pc       = pc;
    i_cycles   = cyc;
    s0 = n_start;
    d0 = n_done;
    poked = 1'b0;
    push_frame(pc, cyc);
    pulse_start();
    lat = 0;
    while (!o_tx_start && lat < 10) begin
      @(negedge i_clock);
      lat++;
    end
    check({name, "_first_start_latency"}, lat, 2);
    cnt = 0;
    while (n_done == d0 && cnt < 20000) begin
      @(negedge i_clock);
      cnt++;
      if (poke) begin
        if (n_start - s0 >= 1) i_pc = 32'hDEAD_BEEF;
        if (n_start - s0 >= 5) i_cycles = 32'h0BAD_F00D;
        if (!poked && n_start - s0 == 50) begin
          pulse_start();
          poked = 1'b1;
        end
      end
    end
    check({name, "_done_in_budget"}, 32'(n_done != d0), 1);
    repeat (5) @(negedge i_clock);
    check({name, "_start_pulses"}, n_start - s0, 648);
    check({name, "_done_pulses"}, n_done - d0, 1);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_busy_after"}, {31'b0, o_busy}, 0);
    exp_q.delete();
    spurious = 1'b0;
  endtask

  task automatic hand(input string name, input int idx, input logic [7:0] exp);
    check(name, {24'b0, got[idx]}, {24'b0, exp});
  endtask

  initial begin
    int g0, s1, cnt;

    // Reset held 5 cycles, with i_start raised during the last reset cycle
    repeat (4) @(negedge i_clock);
    i_start = 1'b1;
    @(negedge i_clock);
    check("rst_tx_start", {31'b0, o_tx_start}, 0);
    check("rst_tx_data", {24'b0, o_tx_data}, 0);
    check("rst_busy", {31'b0, o_busy}, 0);
    check("rst_done", {31'b0, o_done}, 0);
    check("rst_rb_addr", {27'b0, o_rb_addr}, 0);
    check("rst_mem_addr", {25'b0, o_mem_addr}, 0);
    i_reset = 1'b0;
    i_start = 1'b0;
    repeat (5) @(negedge i_clock);
    check("rst_priority_busy", {31'b0, o_busy}, 0);
    check("rst_priority_no_tx", n_start, 0);

    // Full dump
    g0 = got.size();
    run_frame("full", 32'h0000_0040, 32'h0000_0010, 10, 1'b0, 1'b0);
    hand("full_b0", g0 + 0, 8'h40);
    hand("full_b1", g0 + 1, 8'h00);
    hand("full_b3", g0 + 3, 8'h00);
    hand("full_b4", g0 + 4, 8'h10);
    hand("full_b7", g0 + 7, 8'h00);
    hand("full_reg1_b0", g0 + 12, 8'h01);
    hand("full_reg1_b1", g0 + 13, 8'h00);
    hand("full_last_b0", g0 + 644, 8'h7F);
    hand("full_last_b1", g0 + 645, 8'h00);
    hand("full_last_b2", g0 + 646, 8'h00);
    hand("full_last_b3", g0 + 647, 8'hA5);
    check("full_addr_hold_mem", {25'b0, o_mem_addr}, 32'h7F);

    // Start pulse while busy, plus input changes after latching
    g0 = got.size();
    run_frame("busy", 32'h0000_0040, 32'h0000_0010, 10, 1'b0, 1'b1);
    hand("busy_b0", g0 + 0, 8'h40);
    hand("busy_b4", g0 + 4, 8'h10);

    // Spurious done ticks outside WAIT_TX
    g0 = got.size();
    run_frame("spur", 32'h0000_0040, 32'h0000_0010, 10, 1'b1, 1'b0);
    hand("spur_reg1_b0", g0 + 12, 8'h01);
    hand("spur_last_b0", g0 + 644, 8'h7F);

    // Reset mid-dump after byte 100
    uart_delay = 10;
    i_pc = 32'h0000_0040;
    i_cycles = 32'h0000_0010;
    s1 = n_start;
    push_frame(i_pc, i_cycles);
    pulse_start();
    cnt = 0;
    while (n_start - s1 < 100 && cnt < 5000) begin
      @(negedge i_clock);
      cnt++;
    end
    check("mid_reached_byte100", 32'(n_start - s1 >= 100), 1);
    i_reset = 1'b1;
    exp_q.delete();
    @(negedge i_clock);
    i_reset = 1'b0;
    check("mid_busy_cleared", {31'b0, o_busy}, 0);
    check("mid_tx_start_cleared", {31'b0, o_tx_start}, 0);
    s1 = n_start;
    repeat (40) @(negedge i_clock);
    check("mid_no_more_tx", n_start - s1, 0);
    g0 = got.size();
    run_frame("restart", 32'h0000_0040, 32'h0000_0010, 1, 1'b0, 1'b0);
    hand("restart_b0", g0 + 0, 8'h40);

    // Back-to-back: done tick one cycle after each start
    g0 = got.size();
    run_frame("b2b", 32'h1234_5678, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    hand("b2b_b0", g0 + 0, 8'h78);
    hand("b2b_b1", g0 + 1, 8'h56);
    hand("b2b_b2", g0 + 2, 8'h34);
    hand("b2b_b3", g0 + 3, 8'h12);
    hand("b2b_b4", g0 + 4, 8'h0D);
    hand("b2b_b5", g0 + 5, 8'hF0);
    hand("b2b_b6", g0 + 6, 8'hFE);
    hand("b2b_b7", g0 + 7, 8'hCA);
    hand("b2b_reg31_b0", g0 + 8 + 31*4, 8'h1F);
    hand("b2b_mem0_b3", g0 + 136 + 3, 8'hA5);
    hand("b2b_last_b0", g0 + 644, 8'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule
